// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a small in-order output buffer.
// Entries are kept in a shift-register style buffer; slot 0 is always the head,
// so imm/imm_type come straight from flops. Empty slots hold 0/NONE.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5,
    T_Z    = 3'd6,
    T_SH   = 3'd7
  } imm_type_e;

  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  imm_type_e       dec_type;
  logic [XLEN-1:0] dec_imm;
  logic [5:0]      shamt;

  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] imm_q  [DEPTH];
  logic [XLEN-1:0] imm_d  [DEPTH];
  logic [2:0]      type_q [DEPTH];
  logic [2:0]      type_d [DEPTH];

  logic            push, pop;
  logic [CW-1:0]   wr_idx;
  logic            unused_inst_bits;

  assign opcode   = inst[6:2];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // RV32 shifts and the *W shifts only have a 5-bit shamt.
  assign shamt    = ((XLEN == 32) || (opcode == 5'b00110)) ? {1'b0, inst[24:20]} : inst[25:20];
  assign unused_inst_bits = &{1'b0, inst[1:0]};

  // Classify the instruction format from the opcode (and funct3 where it matters).
  always_comb begin
    dec_type = T_NONE;
    case (opcode)
      5'b00000, 5'b11001:  dec_type = T_I;
      5'b00100, 5'b00110:  dec_type = is_shift ? T_SH : T_I;
      5'b11100:            dec_type = funct3[2] ? T_Z : T_I;
      5'b01000:            dec_type = T_S;
      5'b11000:            dec_type = T_B;
      5'b01101, 5'b00101:  dec_type = T_U;
      5'b11011:            dec_type = T_J;
      default:             dec_type = T_NONE;
    endcase
  end

  // Assemble the immediate for the decoded format, sign- or zero-extended to XLEN.
  always_comb begin
    dec_imm = '0;
    case (dec_type)
      T_I:  dec_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      T_S:  dec_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      T_B:  dec_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U:  dec_imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      T_J:  dec_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      T_Z:  dec_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      T_SH: dec_imm = {{(XLEN-6){1'b0}}, shamt};
      default: dec_imm = '0;
    endcase
  end

  // in_ready depends only on registered count, so out_ready never reaches it.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_idx    = count_q - CW'(pop);
  assign imm       = imm_q[0];
  assign imm_type  = type_q[0];

  // Buffer next state: flush wins; otherwise shift out the head on pop, then append on push.
  always_comb begin
    count_d = count_q;
    imm_d   = imm_q;
    type_d  = type_q;
    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_d[i]  = '0;
        type_d[i] = T_NONE;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          imm_d[i]  = imm_q[i+1];
          type_d[i] = type_q[i+1];
        end
        imm_d[DEPTH-1]  = '0;
        type_d[DEPTH-1] = T_NONE;
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) begin
            imm_d[i]  = dec_imm;
            type_d[i] = dec_type;
          end
        end
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i]  <= '0;
        type_q[i] <= T_NONE;
      end
    end else begin
      count_q <= count_d;
      imm_q   <= imm_d;
      type_q  <= type_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance (both DEPTH=2)
// share one stimulus stream and are checked against a queue-based reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  type32;
  logic        in_ready64, out_valid64;
  logic [63:0] imm64;
  logic [2:0]  type64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] v32;
    logic [63:0] v64;
    logic [2:0]  t;
  } ent_t;

  ent_t q[$];
  bit   cleared;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .imm_type(type32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64), .imm_type(type64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sext(input longint val, input int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference decoder written directly from the format rules using integer arithmetic.
  function automatic void ref_decode(input logic [31:0] i, input bit x64,
                                     output logic [63:0] v, output logic [2:0] t);
    logic [4:0] op;
    logic [2:0] f3;
    bit sh;
    op = i[6:2];
    f3 = i[14:12];
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    v = 64'd0;
    t = 3'd0;
    if (op == 5'b00000 || op == 5'b11001 || ((op == 5'b00100 || op == 5'b00110) && !sh) ||
        (op == 5'b11100 && !f3[2])) begin
      t = 3'd1;
      v = sext(longint'(i[31:20]), 12);
    end else if ((op == 5'b00100 || op == 5'b00110) && sh) begin
      t = 3'd7;
      v = (x64 && op == 5'b00100) ? longint'(i[25:20]) : longint'(i[24:20]);
    end else if (op == 5'b01000) begin
      t = 3'd2;
      v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
    end else if (op == 5'b11000) begin
      t = 3'd3;
      v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
               longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
    end else if (op == 5'b01101 || op == 5'b00101) begin
      t = 3'd4;
      v = sext(longint'(i[31:12]) * 4096, 32);
    end else if (op == 5'b11011) begin
      t = 3'd5;
      v = sext(longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 +
               longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
    end else if (op == 5'b11100 && f3[2]) begin
      t = 3'd6;
      v = longint'(i[19:15]);
    end
  endfunction

  function automatic ent_t make_ent(input logic [31:0] i);
    ent_t e;
    logic [63:0] v;
    logic [2:0]  t;
    ref_decode(i, 1'b0, v, t);
    e.v32 = v[31:0];
    e.t   = t;
    ref_decode(i, 1'b1, v, t);
    e.v64 = v;
    return e;
  endfunction

  task automatic check_all(input string where);
    chk({where, ".out_valid32"}, 64'(out_valid32), 64'(q.size() != 0));
    chk({where, ".out_valid64"}, 64'(out_valid64), 64'(q.size() != 0));
    chk({where, ".in_ready32"}, 64'(in_ready32), 64'(q.size() < 2));
    chk({where, ".in_ready64"}, 64'(in_ready64), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk({where, ".imm32"}, 64'(imm32), 64'(q[0].v32));
      chk({where, ".type32"}, 64'(type32), 64'(q[0].t));
      chk({where, ".imm64"}, imm64, q[0].v64);
      chk({where, ".type64"}, 64'(type64), 64'(q[0].t));
    end else if (cleared) begin
      chk({where, ".imm32_clr"}, 64'(imm32), 64'd0);
      chk({where, ".type32_clr"}, 64'(type32), 64'd0);
      chk({where, ".imm64_clr"}, imm64, 64'd0);
      chk({where, ".type64_clr"}, 64'(type64), 64'd0);
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input bit v, input logic [31:0] i, input bit ordy, input bit fl,
                       input string where);
    bit do_push, do_pop;
    in_valid  = v;
    inst      = i;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all(where);
    do_push = v && (q.size() < 2);
    do_pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      cleared = 1'b1;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(make_ent(i));
      if (do_pop || do_push) cleared = 1'b0;
    end
    $display("t=%0t %s v=%0d inst=%08h ordy=%0d flush=%0d push=%0d pop=%0d depth=%0d",
             $time, where, v, i, ordy, fl, do_push && !fl, do_pop && !fl, q.size());
    @(negedge clk);
  endtask

  logic [4:0] ops [10];
  logic [31:0] r;

  initial begin
    ops = '{5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b11100,
            5'b01000, 5'b11000, 5'b01101, 5'b00101, 5'b11011};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = 32'h0;
    cleared = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Known vectors, out_ready held high.
    cycle(1, 32'hFFF00093, 1, 0, "addi");
    chk("addi.imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi.type", 64'(type32), 64'd1);
    chk("addi.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1, 32'hFE20AC23, 1, 0, "sw");
    chk("sw.imm32", 64'(imm32), 64'hFFFF_FFF8);
    chk("sw.type", 64'(type32), 64'd2);
    cycle(1, 32'hFFDFF06F, 1, 0, "jal");
    chk("jal.imm32", 64'(imm32), 64'hFFFF_FFFC);
    chk("jal.type", 64'(type32), 64'd5);
    cycle(1, 32'h123450B7, 1, 0, "lui");
    chk("lui.imm32", 64'(imm32), 64'h1234_5000);
    chk("lui.type", 64'(type32), 64'd4);
    cycle(1, 32'h3002D073, 1, 0, "csrrwi");
    chk("csrrwi.imm32", 64'(imm32), 64'd5);
    chk("csrrwi.type", 64'(type32), 64'd6);
    cycle(1, 32'h03F09093, 1, 0, "slli");
    chk("slli.imm64", imm64, 64'h3F);
    chk("slli.type64", 64'(type64), 64'd7);
    chk("slli.imm32", 64'(imm32), 64'h1F);
    cycle(0, 32'h0, 1, 0, "drain");

    // Backpressure: three back-to-back pushes with out_ready low, then drain.
    cycle(1, 32'h00100093, 0, 0, "bp1");
    cycle(1, 32'h00200093, 0, 0, "bp2");
    chk("bp.in_ready_full", 64'(in_ready32), 64'd0);
    cycle(1, 32'h00300093, 0, 0, "bp3_blocked");
    chk("bp.hold_imm", 64'(imm32), 64'd1);
    cycle(1, 32'h00300093, 1, 0, "bp_pop1");
    cycle(1, 32'h00300093, 1, 0, "bp_pop2");
    chk("bp.third_accepted_head", 64'(imm32), 64'd3);
    cycle(0, 32'h0, 1, 0, "bp_pop3");
    chk("bp.empty", 64'(out_valid32), 64'd0);

    // Flush with two entries held and a simultaneous push.
    cycle(1, 32'h00A00093, 0, 0, "fl_fill1");
    cycle(1, 32'h00B00093, 0, 0, "fl_fill2");
    cycle(1, 32'h00C00093, 1, 1, "flush");
    chk("flush.out_valid", 64'(out_valid32), 64'd0);
    chk("flush.imm", 64'(imm32), 64'd0);
    cycle(0, 32'h0, 1, 0, "post_flush");

    // Asynchronous reset between edges with entries held.
    cycle(1, 32'h00D00093, 0, 0, "ar_fill1");
    cycle(1, 32'h00E00093, 0, 0, "ar_fill2");
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    cleared = 1'b1;
    check_all("async_reset");
    chk("async_reset.out_valid", 64'(out_valid32), 64'd0);
    chk("async_reset.in_ready", 64'(in_ready64), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'hFFF00093, 1, 0, "after_reset");
    chk("after_reset.accepted", 64'(out_valid32), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(3) != 0) r[6:2] = ops[$urandom_range(9)];
      r[1:0] = 2'b11;
      cycle(1'($urandom_range(1)), r, ($urandom_range(3) != 0), ($urandom_range(15) == 0), "rand");
    end
    cycle(0, 32'h0, 1, 0, "rand_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 1 and 2.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have in_ready  output  1  block can accept an instruction this cycle.
REQ-008 SHALL have inst  input  32  instruction word; bits [6:2] are the opcode.
REQ-009 SHALL have out_valid  output  1  head entry valid.
REQ-010 SHALL have out_ready  input  1  downstream accepts the head entry.
REQ-011 SHALL have imm  output  XLEN  head entry immediate.
REQ-012 SHALL have imm_type  output  3  head entry format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH.

Function
REQ-013 SHALL classify by opcode[6:2] as follows.
- I: 00000 LOAD, 00100 OP-IMM with funct3 not 001/101, 00110 OP-IMM-32 with funct3 not 001/101, 11001 JALR, 11100 SYSTEM with funct3[2]=0.
- SH: 00100 or 00110 with funct3 = 001 or 101.
- S: 01000. B: 11000. U: 01101, 00101. J: 11011.
- Z: 11100 with funct3[2]=1.
- NONE: all other opcodes.
REQ-014 SHALL form immediates, sign-extended from inst[31] to XLEN unless stated otherwise.
- I: inst[31:20]. S: {inst[31:25],inst[11:7]}. B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- U: {inst[31:12],12'b0}. J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-015 SHALL zero-extend Z as inst[19:15]; SH as inst[24:20] when XLEN=32 or opcode 00110, else inst[25:20].
REQ-016 SHALL drive imm = 0 for NONE.
REQ-017 SHALL accept an instruction when in_valid && in_ready at a clock edge, and write its imm and imm_type into the buffer at that edge.
REQ-018 SHALL present an accepted entry on out_valid/imm/imm_type in the next cycle (1-cycle latency), in acceptance order.
REQ-019 SHALL pop the head when out_valid && out_ready at a clock edge.
REQ-020 SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from out_ready.
REQ-021 SHALL on simultaneous push and pop keep count unchanged; the new entry becomes tail and the prior second entry, if any, becomes head.
REQ-022 SHALL hold imm and imm_type stable while out_valid && !out_ready.
REQ-023 SHALL give flush priority: count becomes 0 next cycle, any push or pop that cycle is discarded, and imm/imm_type are cleared to 0/NONE.
REQ-024 SHALL use count as its only control state (0..DEPTH); out_valid = (count != 0).

Reset
REQ-025 SHALL on rst_n low immediately set count=0, out_valid=0, in_ready=1, imm=0, imm_type=NONE, including mid-transfer, losing all entries.
REQ-026 SHALL resume accepting on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 SHALL pass: with XLEN=32 and out_ready=1, push 0xFFF00093 -> next cycle imm=0xFFFFFFFF, imm_type=1; push 0xFE20AC23 -> imm=0xFFFFFFF8, imm_type=2.
REQ-028 SHALL pass: push 0xFFDFF06F -> imm=0xFFFFFFFC, type 5; push 0x123450B7 -> imm=0x12345000, type 4; push 0x3002D073 -> imm=0x00000005, type 6.
REQ-029 SHALL pass: with XLEN=64, push 0x03F09093 (slli, shamt 63) -> imm=0x3F, type 7; push 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF.
REQ-030 SHALL pass: with DEPTH=2 and out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts; raise out_ready -> entries drain in order, 3rd accepted once in_ready=1.
REQ-031 SHALL pass: with 2 entries held, assert flush together with in_valid -> next cycle out_valid=0, count=0, pushed instruction absent.
REQ-032 SHALL pass: drop rst_n asynchronously between clock edges with out_valid=1 -> out_valid=0 and in_ready=1 immediately, before the next edge.
